// File: rtl/adc_cmd_sequencer.sv
// adc_cmd_sequencer
// Emits one Avalon-ST packet of ADC conversion commands per accepted
// trigger, reading beats from a small programmable command table.
// Each table entry is {tag[1:0], adc_select[4:0]}.
//
// Output handshake: a beat transfers on a rising edge where
// STout_valid and STout_ready are both high. STout_valid and all other
// STout_* signals come straight from flops, so valid never depends
// combinationally on ready. While valid is high and ready is low, every
// STout_* output holds its value until the beat is taken.
module adc_cmd_sequencer #(
  parameter int MAX_CMDS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [6:0]        cfg_data,
  output logic              STout_valid,
  input  logic              STout_ready,
  output logic              STout_startofpacket,
  output logic              STout_endofpacket,
  output logic [4:0]        STout_data,
  output logic [1:0]        STout_channel,
  output logic              busy,
  output logic [7:0]        overrun_count,
  output logic              state_dbg
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_CMDS);

  state_t            state_q;
  state_t            state_d;
  logic [6:0]        table_q [MAX_CMDS];
  logic [ADDR_W-1:0] index_q;
  logic [ADDR_W-1:0] index_next;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   eff_len;
  logic              sop_q;
  logic              eop_q;
  logic [4:0]        data_q;
  logic [1:0]        chan_q;
  logic [7:0]        overrun_q;
  logic              start_burst;
  logic              advance_beat;
  logic              finish_burst;
  logic              last_beat;
  logic              next_is_last;

  // Requested lengths beyond the table depth replay the whole table once.
  assign eff_len      = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
  assign index_next   = index_q + 1'b1;
  assign last_beat    = ({1'b0, index_q} == (len_q - 1'b1));
  assign next_is_last = ({1'b0, index_next} == (len_q - 1'b1));

  // The FSM state flop doubles as the valid and busy outputs.
  assign STout_valid         = (state_q == SEND);
  assign busy                = (state_q == SEND);
  assign state_dbg           = state_q;
  assign STout_startofpacket = sop_q;
  assign STout_endofpacket   = eop_q;
  assign STout_data          = data_q;
  assign STout_channel       = chan_q;
  assign overrun_count       = overrun_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the per-cycle datapath strobes.
  always_comb begin
    state_d      = state_q;
    start_burst  = 1'b0;
    advance_beat = 1'b0;
    finish_burst = 1'b0;
    case (state_q)
      IDLE: begin
        // A zero-length trigger is silently ignored.
        if (trigger && (eff_len != '0)) begin
          state_d     = SEND;
          start_burst = 1'b1;
        end
      end
      SEND: begin
        if (STout_ready) begin
          if (last_beat) begin
            state_d      = IDLE;
            finish_burst = 1'b1;
          end else begin
            advance_beat = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command table: writable only while idle so a burst always sees a
  // consistent table; a write just before a trigger lands in time.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_CMDS; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_wr && (state_q == IDLE)) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // Output beat registers: load entry 0 on start, next entry on each
  // accepted non-final beat, clear once the final beat is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_q <= '0;
      len_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
    end else if (start_burst) begin
      index_q <= '0;
      len_q   <= eff_len;
      sop_q   <= 1'b1;
      eop_q   <= (eff_len == {{ADDR_W{1'b0}}, 1'b1});
      chan_q  <= table_q[0][6:5];
      data_q  <= table_q[0][4:0];
    end else if (advance_beat) begin
      index_q <= index_next;
      sop_q   <= 1'b0;
      eop_q   <= next_is_last;
      chan_q  <= table_q[index_next][6:5];
      data_q  <= table_q[index_next][4:0];
    end else if (finish_burst) begin
      index_q <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
    end
  end

  // Saturating count of triggers that arrive while a burst is in flight,
  // including the cycle whose edge takes the final beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= '0;
    end else if (trigger && (state_q != IDLE) && (overrun_q != 8'hff)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Testbench for adc_cmd_sequencer: directed stimulus, expected beats
// queued by the driver side, checked by an independent output monitor.
module tb_adc_cmd_sequencer;

  localparam int MAX_CMDS = 8;
  localparam int ADDR_W   = 3;

  logic              clk;
  logic              reset;
  logic              trigger;
  logic [ADDR_W:0]   cfg_len;
  logic              cfg_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [6:0]        cfg_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;
  logic [4:0]        st_data;
  logic [1:0]        st_channel;
  logic              busy;
  logic [7:0]        overrun_count;
  logic              state_dbg;

  // Expected beat = {sop, eop, channel[1:0], data[4:0]}
  logic [8:0] exp_q[$];
  logic [6:0] tbl_model [MAX_CMDS];

  int n_chk = 0;
  int n_err = 0;

  adc_cmd_sequencer #(.MAX_CMDS(MAX_CMDS), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .trigger             (trigger),
    .cfg_len             (cfg_len),
    .cfg_wr              (cfg_wr),
    .cfg_addr            (cfg_addr),
    .cfg_data            (cfg_data),
    .STout_valid         (st_valid),
    .STout_ready         (st_ready),
    .STout_startofpacket (st_sop),
    .STout_endofpacket   (st_eop),
    .STout_data          (st_data),
    .STout_channel       (st_channel),
    .busy                (busy),
    .overrun_count       (overrun_count),
    .state_dbg           (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       held_valid = 1'b0;
  logic [8:0] held_beat;

  always @(negedge clk) begin
    logic [8:0] cur;
    logic [8:0] exp;
    cur = {st_sop, st_eop, st_channel, st_data};
    if (!reset && st_valid) begin
      if (held_valid) begin
        n_chk++;
        if (cur !== held_beat) begin
          n_err++;
          $display("FAIL stall_hold: got %h expected %h", cur, held_beat);
        end
      end
      if (st_ready) begin
        held_valid = 1'b0;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got %h expected none", cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            n_err++;
            $display("FAIL beat: got %h expected %h", cur, exp);
          end
        end
      end else begin
        held_valid = 1'b1;
        held_beat  = cur;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < MAX_CMDS; i++) tbl_model[i] = '0;
  endtask

  task automatic write_entry(input int addr, input logic [6:0] val, input bit update_model);
    cfg_wr   = 1'b1;
    cfg_addr = addr[ADDR_W-1:0];
    cfg_data = val;
    @(posedge clk);
    #1 cfg_wr = 1'b0;
    if (update_model) tbl_model[addr] = val;
  endtask

  // Queue the expected packet, then pulse trigger for one edge.
  task automatic start_burst(input int len, input bit expect_pkt);
    int n;
    n = (len > MAX_CMDS) ? MAX_CMDS : len;
    if (expect_pkt) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({(i == 0), (i == n - 1), tbl_model[i]});
    end
    cfg_len = len[ADDR_W:0];
    trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_drain_timeout"}, (cyc >= 500), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bcnt;
    reset    = 1'b1;
    trigger  = 1'b0;
    cfg_len  = '0;
    cfg_wr   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    st_ready = 1'b1;
    do_reset();

    @(negedge clk);
    check("reset_valid",   st_valid, 0);
    check("reset_sopeop",  {st_sop, st_eop}, 0);
    check("reset_data",    {st_channel, st_data}, 0);
    check("reset_busy",    busy, 0);
    check("reset_overrun", overrun_count, 0);
    @(posedge clk); #1;

    // Table load: entry i = {tag i%4, sel 10+i}
    for (int i = 0; i < MAX_CMDS; i++)
      write_entry(i, {i[1:0], 5'(10 + i)}, 1'b1);

    // Single burst of 4, ready held high; busy must last exactly 4 cycles
    start_burst(4, 1'b1);
    bcnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy) break;
      bcnt++;
    end
    check("busy_cycles", bcnt, 4);
    wait_drain("burst4");

    // Backpressure: ready low for 3 cycles while beat 1 is presented
    start_burst(4, 1'b1);
    @(posedge clk);
    #1 st_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 st_ready = 1'b1;
    wait_drain("stall");

    // Overrun: trigger while beat 2 and beat 3 (final) are accepted
    start_burst(4, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 trigger = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 trigger = 1'b0;
    wait_drain("overrun");
    repeat (4) @(posedge clk);
    #1;
    check("overrun_two", overrun_count, 2);

    // Zero length: nothing happens
    start_burst(0, 1'b0);
    @(negedge clk);
    check("len0_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_overrun", overrun_count, 2);

    // Length 1: single beat with SOP and EOP
    start_burst(1, 1'b1);
    wait_drain("len1");

    // Length 15 clamps to the full table
    start_burst(15, 1'b1);
    wait_drain("len15");

    // Write to entry 3 while busy is dropped; both bursts see the old value
    start_burst(8, 1'b1);
    @(posedge clk);
    #1;
    write_entry(3, 7'h7f, 1'b0);
    wait_drain("wr_busy_a");
    start_burst(8, 1'b1);
    wait_drain("wr_busy_b");

    // Write in the cycle just before a trigger is visible in that burst
    write_entry(0, 7'h55, 1'b1);
    start_burst(2, 1'b1);
    wait_drain("wr_before");

    // Saturation: stall the burst and hold trigger for 300 busy cycles
    st_ready = 1'b0;
    start_burst(4, 1'b1);
    trigger = 1'b1;
    repeat (300) @(posedge clk);
    #1 trigger = 1'b0;
    check("overrun_sat", overrun_count, 255);
    st_ready = 1'b1;
    wait_drain("sat");
    check("overrun_hold", overrun_count, 255);

    // Reset on beat 2: block returns to idle and table clears
    start_burst(4, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    st_ready = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < MAX_CMDS; i++) tbl_model[i] = '0;
    @(negedge clk);
    check("rst_mid_valid",   st_valid, 0);
    check("rst_mid_busy",    busy, 0);
    check("rst_mid_overrun", overrun_count, 0);
    check("rst_mid_data",    {st_sop, st_eop, st_channel, st_data}, 0);
    st_ready = 1'b1;
    @(posedge clk); #1;
    start_burst(8, 1'b1);
    wait_drain("after_reset");

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adc_cmd_sequencer.md
# adc_cmd_sequencer

Generates the per-trigger burst of ADC conversion commands that feeds the channel/data demux-and-swap stage. On each accepted trigger (for example, a PWM-centre strobe) it emits one Avalon-ST packet of `len` beats from a small programmable command table. Each beat carries a 5-bit ADC input select on `STout_data` and a 2-bit result tag on `STout_channel`, with start/end-of-packet framing and full valid/ready backpressure. It also reports triggers lost while a burst is in flight.

## Interface
- `MAX_CMDS`, default 8: command table depth; must be a power of two, range 2..16.
- `ADDR_W`, default 3: equals log2(`MAX_CMDS`).
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `trigger` in 1: single-cycle request to start a burst.
- `cfg_len` in `ADDR_W`+1: burst length, sampled when a trigger is accepted.
- `cfg_wr` in 1: table write strobe.
- `cfg_addr` in `ADDR_W`: table entry index.
- `cfg_data` in 7: entry contents; bits [6:5] are the tag, bits [4:0] are the ADC select.
- `STout_valid` out 1: output beat valid.
- `STout_ready` in 1: downstream ready.
- `STout_startofpacket` out 1: first beat of the burst.
- `STout_endofpacket` out 1: last beat of the burst.
- `STout_data` out 5: ADC select from the current entry.
- `STout_channel` out 2: tag from the current entry.
- `busy` out 1: a burst is in progress.
- `overrun_count` out 8: saturating count of dropped triggers.

## Operation
- Command table: `MAX_CMDS` × 7-bit registers, all zero after reset.
- Table writes:
  - `cfg_wr`=1 with `busy`=0 writes `cfg_data` to entry `cfg_addr` at the clock edge.
  - `cfg_wr` while `busy`=1 is ignored and the table is unchanged.
- FSM state IDLE:
  - `trigger`=1 with effective length ≠0: latch the effective length and go to SEND with index=0.
  - Effective length = `cfg_len` clamped to `MAX_CMDS`.
  - `trigger`=1 with `cfg_len`=0: ignored; no state change and no overrun increment.
- FSM state SEND:
  - The output registers present entry[index].
  - `STout_startofpacket`=1 iff index=0.
  - `STout_endofpacket`=1 iff index=latched length−1.
  - On `STout_valid`&`STout_ready`: if the beat is not the last, index increments and the next entry loads into the output registers in the same edge; if it is the last, go to IDLE and drop `STout_valid`.
- Backpressure: while `STout_valid`=1 and `STout_ready`=0, all `STout_*` outputs hold stable.
- Ready dependency: `STout_valid` never depends combinationally on `STout_ready`.
- Overrun: `trigger`=1 in any cycle where state≠IDLE increments `overrun_count`. This includes the cycle in which the last beat is accepted. The counter saturates at 255. The trigger itself is discarded; there is no queueing.
- `busy`=1 whenever state=SEND.
- Reset mid-burst: the next edge returns the block to IDLE, with all outputs at their reset values and the table cleared. No partial packet resumes.

## Timing
- Reset values: `STout_valid`=0, `STout_startofpacket`=0, `STout_endofpacket`=0, `STout_data`=0, `STout_channel`=0, `busy`=0, `overrun_count`=0.
- All outputs are registered.
- Trigger accepted at edge t: first beat visible (`STout_valid`=1, SOP=1, entry 0) after edge t, i.e. in cycle t+1.
- With `STout_ready` held at 1: one beat per cycle in cycles t+1..t+len. `busy` and `STout_valid` fall after the edge that accepts the last beat.
- Earliest next accepted trigger is cycle t+len+1, giving its first beat at t+len+2. Minimum trigger period is therefore len+1 cycles.
- len=1: a single beat with SOP=1 and EOP=1 together.
- A table write issued in the cycle immediately before a trigger is visible in that burst.

## Test plan
- Table load and single burst:
  - Stimulus: load entries 0..3 = {tag i, sel 10+i}; `cfg_len`=4; trigger with `STout_ready`=1.
  - Required: 4 consecutive beats with data 10,11,12,13 and channel 0,1,2,3; SOP on beat 0 only; EOP on beat 3 only; `busy` high for exactly 4 cycles.
- Backpressure:
  - Stimulus: same burst, with `STout_ready` low for 3 cycles during beat 1.
  - Required: beat 1 fields stable throughout the stall; no beat lost or duplicated; total 4 beats.
- Overrun:
  - Stimulus: trigger during beat 2, then again in the cycle the final beat is accepted.
  - Required: `overrun_count`=2; no second packet emitted.
  - Stimulus: hold `trigger`=1 for 300 busy cycles.
  - Required: `overrun_count` saturates at 255.
- Length edges:
  - `cfg_len`=0 → no output and no overrun increment.
  - `cfg_len`=1 → one beat with SOP=EOP=1.
  - `cfg_len`=15 with `MAX_CMDS`=8 → exactly 8 beats, entries 0..7.
- Writes while busy:
  - Stimulus: `cfg_wr` to entry 3 during a burst.
  - Required: the current burst and the next burst both show the old entry 3 value.
- Reset mid-burst:
  - Stimulus: assert `reset` on beat 2.
  - Required: `STout_valid`=0 and `busy`=0 after the next edge; table reads back zero; next trigger emits beats with data 0 and channel 0.
